icache_miss_memory: RTL and testbench
=====================================

// Module: icache_miss_memory
// PURPOSE
//  Memory-side responder for the instruction cache miss interface. Samples a line-fill request
//  (req_addr_miss/req_valid_miss), waits a fixed latency, then returns one full cache line on
//  rsp_data_miss with a one-cycle rsp_valid_miss pulse. Single outstanding request.
//  A debug write port preloads program contents from the bench or loader.
// PARAMETERS
//  LATENCY    5                    request-sample to rsp_valid_miss, in cycles; legal >= 2
//  NUM_LINES  1024                 lines stored; power of 2
//  ADDR_W     `ICACHE_ADDR_WIDTH   byte address width
//  LINE_W     `ICACHE_LINE_WIDTH   line width in bits; multiple of 8
// PORTS
//  clock           in   1       single clock, rising edge
//  reset           in   1       asynchronous, active-low
//  req_addr_miss   in   ADDR_W  byte address of missing line
//  req_valid_miss  in   1       level request; cache holds it high while missing
//  rsp_data_miss   out  LINE_W  returned line
//  rsp_valid_miss  out  1       one-cycle pulse, data valid
//  dbg_wr_en       in   1       debug line write
//  dbg_wr_addr     in   ADDR_W  byte address of line to write
//  dbg_wr_data     in   LINE_W  line data
//  busy            out  1       1 in any state but IDLE
// BEHAVIOUR
//  Line index = req_addr_miss[log2(LINE_W/8) +: log2(NUM_LINES)]; upper/offset bits ignored.
//  Reset (reset=0): state=IDLE, counter=0, rsp_valid_miss=0, rsp_data_miss=0, busy=0.
//   Array contents are not reset.
//  FSM IDLE -> WAIT -> RESP -> COOL -> IDLE:
//   IDLE: edge with req_valid_miss=1 captures line index, loads counter=LATENCY-2, -> WAIT
//     (LATENCY=2: counter=0, WAIT lasts one cycle).
//   WAIT: counter decrements each edge; at the edge where counter==0, array is read into
//     rsp_data_miss, -> RESP.
//   RESP: rsp_valid_miss=1 for exactly this cycle; -> COOL.
//   COOL: one cycle, req_valid_miss ignored (cache still sees stale miss this cycle); -> IDLE.
//  Latency: request sampled at edge ending cycle T -> rsp_valid_miss high in cycle T+LATENCY.
//   Next request sampled no earlier than the edge ending cycle T+LATENCY+2.
//  rsp_data_miss holds last returned line until the next RESP; 0 after reset.
//  req_valid_miss / req_addr_miss in WAIT, RESP, COOL ignored unless MEM_REQ_ABORT_EN.
//  dbg_wr_en: line written at the edge, in any state.
//   Read on the same edge as a write to the same line returns old data (read-first).
//  Reset asserted mid-request: FSM returns to IDLE immediately; no response is issued.
// CONFIGURATION
//  MEM_REQ_ABORT_EN defined, in WAIT only:
//   - req_valid_miss=1 with a line index different from the captured one: recapture, reload
//     counter=LATENCY-2, stay in WAIT. Latency restarts from the new sample.
//   - req_valid_miss=0: -> IDLE, no response.
//  MEM_REQ_ABORT_EN undefined: captured request always completes; redirects are ignored.
// STRUCTURE
//  Shared package mem_pkg:
//   - mem_state_t enum {IDLE, WAIT, RESP, COOL}
//   - MEM_LINE_OFFSET_W, MEM_IDX_W localparams
//   - line_idx() function
//  Sub-module mem_line_array: NUM_LINES x LINE_W storage, one sync read port, one sync
//   write port, read-first. Top holds FSM, counter, capture and output registers.
// TESTING
//  1 Preload line 3 = 128'hA5..A5; req 0x30 held high from cycle 0 -> rsp_valid_miss cycle 5, data A5..A5, busy 0 at cycle 7.
//  2 req_valid_miss held high after response -> no second pulse in COOL; new sample cycle 7, response cycle 12.
//  3 Write line 3 = B6..B6 in cycle 4 of a line-3 fetch (read edge) -> returns A5..A5; next fetch returns B6..B6.
//  4 Address change 0x30->0x40 in WAIT -> ABORT_EN: single response, line 4, 5 cycles after the change;
//    without: line 3 at cycle 5.
//  5 reset=0 in cycle 3 of a fetch -> no rsp_valid_miss; busy=0 asynchronously; fresh fetch after release
//    gets full LATENCY.
//  6 LATENCY=2 build: back-to-back held requests -> pulses at cycles 2, 6, 10.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared state type, index widths and line-index helper for the icache miss memory.
// ICACHE_ADDR_WIDTH / ICACHE_LINE_WIDTH fall back to 32 / 128 when the build does not define them.
`ifndef ICACHE_ADDR_WIDTH
`define ICACHE_ADDR_WIDTH 32
`endif
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP, COOL} mem_state_t;

    localparam int MEM_ADDR_W        = `ICACHE_ADDR_WIDTH;
    localparam int MEM_LINE_W        = `ICACHE_LINE_WIDTH;
    localparam int MEM_NUM_LINES     = 1024;
    localparam int MEM_LINE_OFFSET_W = $clog2(MEM_LINE_W / 8);
    localparam int MEM_IDX_W         = $clog2(MEM_NUM_LINES);

    // Drops the byte-offset bits; the caller truncates to its own index width.
    function automatic logic [MEM_ADDR_W-1:0] line_idx(input logic [MEM_ADDR_W-1:0] addr,
                                                      input int unsigned off_w);
        return addr >> off_w;
    endfunction
endpackage

// File: rtl/mem_line_array.sv
// Line storage: one synchronous read port and one synchronous write port, read-first.
// The read register is reset so the returned line reads 0 until the first fetch.
module mem_line_array #(
    parameter int NUM_LINES = 1024,
    parameter int LINE_W    = 128,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LINE_W-1:0] wr_data
);
    logic [LINE_W-1:0] mem_q [NUM_LINES];
    logic [LINE_W-1:0] rd_data_d;
    logic [LINE_W-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/icache_miss_memory.sv
// Fixed-latency line-fill responder for the icache miss port, single outstanding request.
// Define MEM_REQ_ABORT_EN to let the cache redirect or withdraw a request while it is waiting.
module icache_miss_memory
    import mem_pkg::*;
#(
    parameter int LATENCY   = 5,
    parameter int NUM_LINES = 1024,
    parameter int ADDR_W    = `ICACHE_ADDR_WIDTH,
    parameter int LINE_W    = `ICACHE_LINE_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req_addr_miss,
    input  logic              req_valid_miss,
    output logic [LINE_W-1:0] rsp_data_miss,
    output logic              rsp_valid_miss,
    input  logic              dbg_wr_en,
    input  logic [ADDR_W-1:0] dbg_wr_addr,
    input  logic [LINE_W-1:0] dbg_wr_data,
    output logic              busy
);
    // state | meaning
    // IDLE  | waiting for req_valid_miss
    // WAIT  | latency countdown, line read on the edge where the counter hits 0
    // RESP  | rsp_valid_miss high, rsp_data_miss valid
    // COOL  | one dead cycle while the cache drops its stale miss
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    mem_state_t       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic             busy_d, busy_q;
    logic             rsp_valid_d, rsp_valid_q;
    logic             rd_en;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] wr_idx;

    assign req_idx = IDX_W'(line_idx(MEM_ADDR_W'(req_addr_miss), OFF_W));
    assign wr_idx  = IDX_W'(line_idx(MEM_ADDR_W'(dbg_wr_addr), OFF_W));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_miss) begin
                    idx_d   = req_idx;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
`ifdef MEM_REQ_ABORT_EN
                // A redirect restarts the full latency from the new sample.
                if (!req_valid_miss) begin
                    state_d = IDLE;
                end else if (req_idx != idx_q) begin
                    idx_d = req_idx;
                    cnt_d = CNT_LOAD;
                end else
`endif
                if (cnt_q == '0) begin
                    rd_en   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    mem_line_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_W    (LINE_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_idx  (idx_q),
        .rd_data (rsp_data_miss),
        .wr_en   (dbg_wr_en),
        .wr_idx  (wr_idx),
        .wr_data (dbg_wr_data)
    );

    assign rsp_valid_miss = rsp_valid_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_icache_miss_memory.sv
// Self-checking bench for icache_miss_memory: table vectors, directed corner sequences and
// a randomized run against a cycle-level reference model of the request/response timing.
`ifndef ICACHE_ADDR_WIDTH
`define ICACHE_ADDR_WIDTH 32
`endif
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

module tb_icache_miss_memory;
    localparam int AW     = `ICACHE_ADDR_WIDTH;
    localparam int LW     = `ICACHE_LINE_WIDTH;
    localparam int LAT    = 5;
    localparam int NL     = 1024;
    localparam int LBYTES = LW / 8;
    typedef logic [LW-1:0] line_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_valid = 1'b0;
    logic          dbg_wr_en = 1'b0;
    logic [AW-1:0] dbg_wr_addr = '0;
    line_t         dbg_wr_data = '0;
    line_t         rsp_data;
    logic          rsp_valid, busy;
    logic [AW-1:0] req2_addr = '0;
    logic          req2_valid = 1'b0;
    line_t         rsp2_data;
    logic          rsp2_valid, busy2;

    always #5 clock = ~clock;

    icache_miss_memory #(.LATENCY(LAT), .NUM_LINES(NL), .ADDR_W(AW), .LINE_W(LW)) u_dut (
        .clock(clock), .reset(reset),
        .req_addr_miss(req_addr), .req_valid_miss(req_valid),
        .rsp_data_miss(rsp_data), .rsp_valid_miss(rsp_valid),
        .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
        .busy(busy));

    icache_miss_memory #(.LATENCY(2), .NUM_LINES(NL), .ADDR_W(AW), .LINE_W(LW)) u_dut2 (
        .clock(clock), .reset(reset),
        .req_addr_miss(req2_addr), .req_valid_miss(req2_valid),
        .rsp_data_miss(rsp2_data), .rsp_valid_miss(rsp2_valid),
        .dbg_wr_en(1'b0), .dbg_wr_addr('0), .dbg_wr_data('0),
        .busy(busy2));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: a pending request is described by its sample cycle and response cycle.
    line_t       mdl_mem [NL];
    bit          m_pend = 1'b0;
    int          m_samp = 0, m_resp = 0, m_free = 0;
    int          m_idx = 0;
    line_t       m_data = '0;

    bit    valid_log [int];
    bit    busy_log  [int];
    line_t data_log  [int];
    bit    v2_log    [int];
    bit    b2_log    [int];

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'((a / LBYTES) % NL);
    endfunction

    function automatic line_t pat(input int i);
        line_t r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        return r;
    endfunction

    function automatic line_t fill(input logic [7:0] b);
        return {LBYTES{b}};
    endfunction

    function automatic int pulses(input int a, input int b, input bit second);
        int n = 0;
        for (int k = a; k <= b; k++) begin
            if (!second && valid_log.exists(k) && valid_log[k]) n++;
            if (second && v2_log.exists(k) && v2_log[k]) n++;
        end
        return n;
    endfunction

    task automatic chk(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Applies the model for the edge that ends the current cycle.
    task automatic model_edge();
        int c = cyc;
        if (!reset) begin
            m_pend = 1'b0;
            m_free = 0;
            m_data = '0;
            return;
        end
        if (m_pend && c >= m_resp) m_pend = 1'b0;
`ifdef MEM_REQ_ABORT_EN
        if (m_pend && c < m_resp) begin
            if (!req_valid) begin
                m_pend = 1'b0;
                m_free = c + 1;
            end else if (idx_of(req_addr) != m_idx) begin
                m_samp = c;
                m_resp = c + LAT;
                m_free = c + LAT + 2;
                m_idx  = idx_of(req_addr);
            end
        end
`endif
        if (m_pend && c == m_resp - 1) m_data = mdl_mem[m_idx];
        if (!m_pend && c >= m_free && req_valid) begin
            m_pend = 1'b1;
            m_samp = c;
            m_resp = c + LAT;
            m_free = c + LAT + 2;
            m_idx  = idx_of(req_addr);
        end
        if (dbg_wr_en) mdl_mem[idx_of(dbg_wr_addr)] = dbg_wr_data;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        cyc++;
        valid_log[cyc] = rsp_valid;
        busy_log[cyc]  = busy;
        data_log[cyc]  = rsp_data;
        v2_log[cyc]    = rsp2_valid;
        b2_log[cyc]    = busy2;
        chk("rsp_valid", line_t'(rsp_valid), line_t'(m_pend && cyc == m_resp));
        chk("busy", line_t'(busy), line_t'(cyc < m_free));
        chk("rsp_data", rsp_data, m_data);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        line_t         exp_data;
    } vec_t;

    vec_t vecs [6];
    int   s, s2, drop;
    line_t rnd;

    initial begin
        vecs[0] = '{addr: 32'h0000_0030, exp_data: pat(3)};
        vecs[1] = '{addr: 32'h0000_0047, exp_data: pat(4)};
        vecs[2] = '{addr: 32'hFFFF_FC3F, exp_data: pat(963)};
        vecs[3] = '{addr: 32'h0000_4010, exp_data: pat(1)};
        vecs[4] = '{addr: 32'h0000_3FF0, exp_data: pat(1023)};
        vecs[5] = '{addr: 32'h8000_0000, exp_data: pat(0)};

        @(posedge clock);
        #1;
        chk("reset_valid", line_t'(rsp_valid), '0);
        chk("reset_busy", line_t'(busy), '0);
        chk("reset_data", rsp_data, '0);
        chk("reset_busy2", line_t'(busy2), '0);
        reset = 1'b1;

        for (int i = 0; i < NL; i++) begin
            dbg_wr_en   = 1'b1;
            dbg_wr_addr = AW'(i * LBYTES);
            dbg_wr_data = pat(i);
            step();
        end
        dbg_wr_en = 1'b0;

        foreach (vecs[v]) begin
            s = cyc;
            req_addr  = vecs[v].addr;
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            repeat (LAT + 1) step();
            chk("tbl_pulse", line_t'(valid_log[s + LAT]), line_t'(1));
            chk("tbl_data", data_log[s + LAT], vecs[v].exp_data);
            chk("tbl_count", line_t'(pulses(s + 1, s + LAT + 1, 1'b0)), line_t'(1));
            chk("tbl_idle", line_t'(busy_log[s + LAT + 2]), '0);
        end

        // Held request: pulse at +5, nothing in COOL, resample at +7 -> pulse at +12.
        dbg_wr_en = 1'b1; dbg_wr_addr = 32'h30; dbg_wr_data = fill(8'hA5);
        step();
        dbg_wr_en = 1'b0;
        s = cyc;
        req_addr = 32'h30; req_valid = 1'b1;
        repeat (14) step();
        req_valid = 1'b0;
        repeat (3) step();
        chk("held_pulse1", line_t'(valid_log[s + 5]), line_t'(1));
        chk("held_data", data_log[s + 5], fill(8'hA5));
        chk("held_cool", line_t'(valid_log[s + 6]), '0);
        chk("held_idle", line_t'(busy_log[s + 7]), '0);
        chk("held_pulse2", line_t'(valid_log[s + 12]), line_t'(1));
        chk("held_count", line_t'(pulses(s + 1, s + 17, 1'b0)), line_t'(2));

        // Write on the read edge: old line returned, new line on the next fetch.
        s = cyc;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        dbg_wr_en = 1'b1; dbg_wr_addr = 32'h35; dbg_wr_data = fill(8'hB6);
        step();
        dbg_wr_en = 1'b0;
        repeat (3) step();
        chk("rf_old", data_log[s + 5], fill(8'hA5));
        s = cyc;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (6) step();
        chk("rf_new", data_log[s + 5], fill(8'hB6));

        // Address change in WAIT.
        s = cyc;
        req_addr = 32'h30; req_valid = 1'b1;
        step();
        step();
        req_addr = 32'h40;
`ifdef MEM_REQ_ABORT_EN
        drop = 8;
`else
        drop = 5;
`endif
        while (cyc < s + drop) step();
        req_valid = 1'b0;
        while (cyc < s + 12) step();
        chk("redir_count", line_t'(pulses(s + 1, s + 12, 1'b0)), line_t'(1));
`ifdef MEM_REQ_ABORT_EN
        chk("redir_pulse", line_t'(valid_log[s + 7]), line_t'(1));
        chk("redir_data", data_log[s + 7], pat(4));
`else
        chk("redir_pulse", line_t'(valid_log[s + 5]), line_t'(1));
        chk("redir_data", data_log[s + 5], fill(8'hB6));
`endif

        // Reset in cycle 3 of a fetch.
        s = cyc;
        req_addr = 32'h30; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_busy_async", line_t'(busy), '0);
        chk("rst_valid_async", line_t'(rsp_valid), '0);
        chk("rst_data_async", rsp_data, '0);
        step();
        reset = 1'b1;
        repeat (2) step();
        s2 = cyc;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (6) step();
        chk("rst_no_pulse", line_t'(pulses(s + 1, s2 + 4, 1'b0)), '0);
        chk("rst_fresh_pulse", line_t'(valid_log[s2 + 5]), line_t'(1));
        chk("rst_fresh_data", data_log[s2 + 5], fill(8'hB6));

        // LATENCY=2 instance, back-to-back held requests.
        s = cyc;
        req2_addr = 32'h30; req2_valid = 1'b1;
        repeat (11) step();
        req2_valid = 1'b0;
        step();
        chk("lat2_p1", line_t'(v2_log[s + 2]), line_t'(1));
        chk("lat2_p2", line_t'(v2_log[s + 6]), line_t'(1));
        chk("lat2_p3", line_t'(v2_log[s + 10]), line_t'(1));
        chk("lat2_idle", line_t'(b2_log[s + 4]), '0);
        chk("lat2_count", line_t'(pulses(s + 1, s + 12, 1'b1)), line_t'(3));

        // Randomized traffic over a small set of lines.
        for (int n = 0; n < 3000; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                req_addr = (AW'($urandom) & ~(AW'(32'h3FF) << 4)) | (AW'($urandom_range(0, 15)) << 4);
            dbg_wr_en = ($urandom_range(0, 5) == 0);
            dbg_wr_addr = AW'($urandom_range(0, 15) * LBYTES + $urandom_range(0, LBYTES - 1));
            for (int k = 0; k < LW / 32; k++) rnd[k*32 +: 32] = $urandom;
            dbg_wr_data = rnd;
            step();
        end
        req_valid = 1'b0;
        dbg_wr_en = 1'b0;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
